// File: rtl/bus_sync_sender_pkg.sv
// Shared definitions for the bus synchronizer source-side launcher:
// FSM state encoding and synchronizer depth limits.
package bus_sync_sender_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_REQ  = 2'b01;
  localparam state_t ST_REL  = 2'b10;

  localparam int MIN_SYNC_STAGES = 2;

  // Clamp a requested synchronizer depth so a chain never drops below two flops.
  function automatic int sync_depth(input int requested);
    return (requested < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : requested;
  endfunction

endpackage

// File: rtl/bus_sync_sender_if.sv
// Upstream valid/ready port plus the request/acknowledge pair toward the
// destination-domain synchronizer, bundled for the sender.
interface bus_sync_sender_if #(
  parameter int BUS_WIDTH = 8
);

  logic [BUS_WIDTH-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] un_sync_bus;
  logic                 bus_en;
  logic                 sync_ack;
  logic                 busy;
  logic                 done;

  // The sender itself.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output un_sync_bus,
    output bus_en,
    input  sync_ack,
    output busy,
    output done
  );

  // Upstream producer plus destination-side responder.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  un_sync_bus,
    input  bus_en,
    output sync_ack,
    input  busy,
    input  done
  );

endinterface

// File: rtl/bus_sync_sender_bit_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-high reset to 0.
module bit_sync
  import bus_sync_sender_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  localparam int STAGES = sync_depth(NUM_STAGES);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bus_sync_sender.sv
// Source-domain launcher: captures a word, holds it on the bus and runs a
// 4-phase request/acknowledge handshake against the destination domain.
module bus_sync_sender
  import bus_sync_sender_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_sync_sender_if.slave     bus
);

  logic                 ack_sync;
  state_t               state_q,  state_d;
  logic [BUS_WIDTH-1:0] data_q,   data_d;
  logic                 bus_en_q, bus_en_d;
  logic                 done_q,   done_d;
  logic                 in_ready;

  bit_sync #(
    .NUM_STAGES (NUM_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.sync_ack),
    .q_o (ack_sync)
  );

  // A stale acknowledge left over from an aborted handshake blocks new accepts.
  assign in_ready = (state_q == ST_IDLE) && !ack_sync;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    bus_en_d = bus_en_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready) begin
          data_d   = bus.in_data;
          bus_en_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_sync) begin
          bus_en_d = 1'b0;
          state_d  = ST_REL;
        end
      end
      ST_REL: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        bus_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      bus_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      bus_en_q <= bus_en_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.un_sync_bus = data_q;
  assign bus.bus_en      = bus_en_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_bus_sync_sender.sv
// Directed bench for bus_sync_sender: vector table for one full handshake plus
// sequences for back-to-back traffic, reset mid-handshake and a stuck acknowledge.
module tb_bus_sync_sender;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       expReady;
    logic       expBusEn;
    logic       expBusy;
    logic       expDone;
    logic [7:0] expBus;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ackManual;
  logic       respMode;
  logic [2:0] ackDelay;
  int         checks   = 0;
  int         failures = 0;

  bus_sync_sender_if #(.BUS_WIDTH(8)) bus ();

  bus_sync_sender #(
    .NUM_STAGES (2),
    .BUS_WIDTH  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Destination responder: either driven directly or echoing BUS_EN three cycles late.
  always @(posedge clk or posedge rst) begin
    if (rst) ackDelay <= 3'b000;
    else     ackDelay <= {ackDelay[1:0], bus.bus_en};
  end

  assign bus.sync_ack = respMode ? ackDelay[2] : ackManual;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ack);
    bus.in_valid = valid;
    bus.in_data  = data;
    ackManual    = ack;
  endtask

  vec_t       vecs[15];
  logic [7:0] words[3];
  logic [7:0] accepted[3];

  initial begin
    int   acceptCnt;
    int   doneCnt;
    int   violations;
    int   idx;
    logic preAccept;
    logic preBusy;
    logic [7:0] preBus;
    logic [7:0] preData;

    // valid data ack | ready bus_en busy done bus
    vecs[0]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3};
    vecs[2]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[4]  = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3};
    vecs[7]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A};
    words[0] = 8'hC3;
    words[1] = 8'hFF;
    words[2] = 8'hAA;

    rst      = 1'b1;
    respMode = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    stepCycle();
    checkOutput("rst_bus_en", 32'(bus.bus_en), 32'h0);
    checkOutput("rst_bus", 32'(bus.un_sync_bus), 32'h00);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    stepCycle();
    checkOutput("rst_ready_after", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].ack);
      stepCycle();
      checkOutput($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d_bus_en", i), 32'(bus.bus_en), 32'(vecs[i].expBusEn));
      checkOutput($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].expDone));
      checkOutput($sformatf("v%0d_bus", i), 32'(bus.un_sync_bus), 32'(vecs[i].expBus));
    end

    $display("[TB] back-to-back with delayed responder");
    respMode   = 1'b1;
    acceptCnt  = 0;
    doneCnt    = 0;
    violations = 0;
    idx        = 0;
    applyStimulus(1'b1, words[0], 1'b0);
    for (int cyc = 0; cyc < 300 && doneCnt < 3; cyc++) begin
      preAccept = bus.in_valid && bus.in_ready;
      preBusy   = bus.busy;
      preBus    = bus.un_sync_bus;
      preData   = bus.in_data;
      stepCycle();
      if (preBusy && (bus.un_sync_bus !== preBus)) violations++;
      if (bus.done) doneCnt++;
      if (preAccept) begin
        if (acceptCnt < 3) accepted[acceptCnt] = preData;
        acceptCnt++;
        checkOutput($sformatf("b2b_capture%0d", acceptCnt), 32'(bus.un_sync_bus), 32'(preData));
        idx++;
        if (idx < 3) bus.in_data = words[idx];
        else         bus.in_valid = 1'b0;
      end
    end
    checkOutput("b2b_done_count", 32'(doneCnt), 32'd3);
    checkOutput("b2b_accept_count", 32'(acceptCnt), 32'd3);
    checkOutput("b2b_bus_stable", 32'(violations), 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("b2b_order%0d", i), 32'(accepted[i]), 32'(words[i]));
    end
    respMode = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepCycle();

    $display("[TB] reset mid-handshake");
    applyStimulus(1'b1, 8'h3C, 1'b0);
    stepCycle();
    checkOutput("mid_accept_bus", 32'(bus.un_sync_bus), 32'h3C);
    applyStimulus(1'b0, 8'h00, 1'b1);
    stepCycle();
    checkOutput("mid_still_req", 32'(bus.bus_en), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_bus_en", 32'(bus.bus_en), 32'h0);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("mid_rst_bus", 32'(bus.un_sync_bus), 32'h00);
    checkOutput("mid_rst_done", 32'(bus.done), 32'h0);
    #1;
    rst = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("stale_ready_low", 32'(bus.in_ready), 32'h0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    stepCycle();
    checkOutput("stale_no_capture_busy", 32'(bus.busy), 32'h0);
    checkOutput("stale_no_capture_bus", 32'(bus.un_sync_bus), 32'h00);
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepCycle();
    checkOutput("stale_ready_low2", 32'(bus.in_ready), 32'h0);
    stepCycle();
    checkOutput("stale_ready_back", 32'(bus.in_ready), 32'h1);

    $display("[TB] stuck acknowledge");
    applyStimulus(1'b1, 8'h99, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stuck_bus", 32'(bus.un_sync_bus), 32'h99);
    for (int cyc = 0; cyc < 100; cyc++) begin
      stepCycle();
      checkOutput($sformatf("stuck%0d_bus_en", cyc), 32'(bus.bus_en), 32'h1);
      checkOutput($sformatf("stuck%0d_busy", cyc), 32'(bus.busy), 32'h1);
      checkOutput($sformatf("stuck%0d_done", cyc), 32'(bus.done), 32'h0);
      checkOutput($sformatf("stuck%0d_ready", cyc), 32'(bus.in_ready), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_sync_sender.md
# bus_sync_sender

Source-domain launcher for the multi-flop bus synchronizer. It accepts a word on a valid/ready interface, holds it stable on UN_SYNC_BUS, and raises the level request BUS_EN toward the destination-domain DATA_SYNC. It then completes a 4-phase handshake using SYNC_ACK, an acknowledge returned from the destination domain and synchronized internally. This guarantees the bus never changes while the far side may be sampling it.

## Interface
- NUM_STAGES, 2, flop count of the internal SYNC_ACK synchronizer (≥2)
- BUS_WIDTH, 8, data word width
- CLK  in  1  source-domain clock
- RST  in  1  asynchronous, active-high reset
- IN_DATA  in  BUS_WIDTH  word to transfer
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  block can accept a word this cycle
- UN_SYNC_BUS  out  BUS_WIDTH  registered data toward destination synchronizer
- BUS_EN  out  1  registered level request toward destination synchronizer
- SYNC_ACK  in  1  acknowledge from destination domain, asynchronous to CLK
- BUSY  out  1  handshake in progress (state ≠ IDLE)
- DONE  out  1  one-cycle pulse, transfer fully complete

## Operation
- Internal ack_sync = SYNC_ACK delayed through NUM_STAGES flops clocked by CLK, all reset to 0.
- FSM states: IDLE, REQ, REL.
  - IDLE: IN_READY = !ack_sync. On an edge with IN_VALID && IN_READY: UN_SYNC_BUS ← IN_DATA, BUS_EN ← 1, go to REQ.
  - REQ: hold UN_SYNC_BUS and BUS_EN. On an edge with ack_sync == 1: BUS_EN ← 0, go to REL.
  - REL: UN_SYNC_BUS still held. On an edge with ack_sync == 0: go to IDLE and set DONE ← 1 for one cycle.
- IN_READY is combinational: (state == IDLE) && !ack_sync. It is 0 in REQ and REL.
- UN_SYNC_BUS changes only on an accepting edge. Otherwise it holds the last transferred word indefinitely.
- IN_VALID while IN_READY = 0 is ignored. The word is not captured, and the upstream must hold it.
- Stale ack (ack_sync still 1 in IDLE, e.g. after reset): IN_READY stays 0 until ack_sync returns to 0.
- There is no timeout. If SYNC_ACK never toggles, the block stays in REQ or REL.

## Timing
- Reset values: state IDLE, UN_SYNC_BUS 0, BUS_EN 0, BUSY 0, DONE 0, ack_sync chain 0. IN_READY reads 1 while RST is high, but no capture occurs.
- Reset mid-handshake: all outputs return to reset values immediately, asynchronously. Recovery follows the stale-ack rule.
- Let edge E0 accept a word. BUS_EN and the new UN_SYNC_BUS are valid after E0, and BUSY = 1 from E0.
- Ack latency: if Ea is the first edge sampling SYNC_ACK = 1, BUS_EN falls at edge Ea+NUM_STAGES.
- If Eb is the first edge sampling SYNC_ACK = 0, the FSM enters IDLE and DONE is high for the one cycle after edge Eb+NUM_STAGES. IN_READY is 1 in that same cycle.
- Zero-delay responder (SYNC_ACK = BUS_EN): a transfer occupies 2·(NUM_STAGES+1) cycles, so the next accept happens no earlier than E0+2·(NUM_STAGES+1).
- The DONE cycle may coincide with a new accept. Back-to-back transfers are allowed.

## Structure
- Shared package: FSM state encoding (IDLE = 2'b00, REQ = 2'b01, REL = 2'b10) and the minimum NUM_STAGES constant (2).
- One sub-module: bit_sync, a parameterized NUM_STAGES single-bit flop chain with async active-high reset to 0. It synchronizes SYNC_ACK.
- Top level contains the FSM and the data/request registers only. No combinational path runs from SYNC_ACK to any output.

## Test plan
- Reset: RST high for 1 cycle → BUS_EN = 0, UN_SYNC_BUS = 8'h00, BUSY = 0, DONE = 0; IN_READY = 1 after release.
- Single transfer, zero-delay responder, NUM_STAGES = 2: IN_DATA = 8'hC3 accepted at E0 → BUS_EN high E0–E3, UN_SYNC_BUS = 8'hC3 throughout, DONE pulses after E6, IN_READY = 0 from E0 until E6.
- Back-to-back: words 8'hC3, 8'hFF, 8'hAA with IN_VALID held high, responder delay 3 cycles → each word is accepted exactly once, in order. UN_SYNC_BUS never changes while BUS_EN = 1 or while in REL.
- Backpressure: IN_VALID pulsed for one cycle with 8'h55 while in REQ → word not captured, UN_SYNC_BUS unchanged, no extra BUS_EN pulse.
- Reset mid-handshake: assert RST while in REQ with SYNC_ACK = 1 held by the responder → BUS_EN = 0 immediately. After release, IN_READY stays 0 until SYNC_ACK is dropped and has propagated through the NUM_STAGES = 2 synchronizer, then returns to 1.
- Stuck ack: the responder never raises SYNC_ACK → BUS_EN and BUSY stay 1, DONE never pulses, IN_READY stays 0 for 100 cycles.
